// File: rtl/rep_sub_div.sv
// Sequential 16-bit unsigned divider by repeated subtraction.
// Operands arrive on a shared bus in two cycles. Quotient and remainder are latched with a one-cycle done pulse.
module rep_sub_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] data_in,
  output logic [15:0] quot,
  output logic [15:0] remd,
  output logic        done,
  output logic        busy,
  output logic        dz
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_B = 2'd1,
    SUB    = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic [15:0] rem_r;
  logic [15:0] div_r;
  logic [15:0] cnt_r;
  logic        div_zero_s;
  logic        rem_ge_s;
  logic        busy_next_s;
  logic        done_next_s;

  // True when another subtraction step fits without underflow.
  function automatic logic step_fits(input logic [15:0] r, input logic [15:0] b);
    step_fits = (r >= b);
  endfunction

  // Datapath status flags used by both the FSM and the datapath registers.
  always_comb begin
    div_zero_s = (div_r == 16'd0);
    rem_ge_s   = step_fits(rem_r, div_r);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = IDLE;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = LOAD_B;
        end else begin
          state_next_s = IDLE;
        end
      end
      LOAD_B: state_next_s = SUB;
      SUB: begin
        if (div_zero_s || !rem_ge_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = SUB;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Output decode from the upcoming state, so the flags can be registered without added latency.
  always_comb begin
    busy_next_s = 1'b0;
    done_next_s = 1'b0;
    case (state_next_s)
      IDLE: begin
        busy_next_s = 1'b0;
        done_next_s = 1'b0;
      end
      LOAD_B, SUB: begin
        busy_next_s = 1'b1;
        done_next_s = 1'b0;
      end
      DONE: begin
        busy_next_s = 1'b1;
        done_next_s = 1'b1;
      end
      default: begin
        busy_next_s = 1'b0;
        done_next_s = 1'b0;
      end
    endcase
  end

  // Registered status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= busy_next_s;
      done <= done_next_s;
    end
  end

  // Working registers and result latches. Results move only on the SUB->DONE transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_r <= 16'd0;
      div_r <= 16'd0;
      cnt_r <= 16'd0;
      quot  <= 16'd0;
      remd  <= 16'd0;
      dz    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            rem_r <= data_in;
            cnt_r <= 16'd0;
          end
        end
        LOAD_B: begin
          div_r <= data_in;
        end
        SUB: begin
          if (div_zero_s) begin
            quot <= 16'hFFFF;
            remd <= rem_r;
            dz   <= 1'b1;
          end else if (rem_ge_s) begin
            rem_r <= rem_r - div_r;
            cnt_r <= cnt_r + 16'd1;
          end else begin
            quot <= cnt_r;
            remd <= rem_r;
            dz   <= 1'b0;
          end
        end
        DONE: begin
          rem_r <= rem_r;
        end
        default: begin
          rem_r <= 16'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rep_sub_div.sv
// Self-checking bench for rep_sub_div: directed cases, randomized operands against a
// plain-arithmetic reference, ignored-start noise, worst-case latency and mid-operation reset.
module tb_rep_sub_div;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] data_in;
  logic [15:0] quot;
  logic [15:0] remd;
  logic        done;
  logic        busy;
  logic        dz;

  int          n_cmp;
  int          n_fail;
  logic [15:0] last_q;
  logic [15:0] last_r;
  logic        last_dz;

  rep_sub_div dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .data_in (data_in),
    .quot    (quot),
    .remd    (remd),
    .done    (done),
    .busy    (busy),
    .dz      (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One complete operation: drives a then b, waits for done and checks against a/b, a%b.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input bit noise, input string name);
    logic [15:0] eq;
    logic [15:0] er;
    logic        edz;
    int          elat;
    int          edges;
    bit          seen;
    bit          hold_bad;
    bit          busy_bad;
    if (b == 16'd0) begin
      eq = 16'hFFFF; er = a; edz = 1'b1; elat = 2;
    end else begin
      eq = a / b; er = a % b; edz = 1'b0; elat = int'(a / b) + 2;
    end
    start = 1'b1; data_in = a;
    @(posedge clk); #1;
    start = 1'b0; data_in = b;
    @(posedge clk); #1;
    data_in = 16'($urandom);
    edges = 1; seen = 0; hold_bad = 0; busy_bad = 0;
    while (!seen && edges < 70000) begin
      if (noise) begin
        start   = 1'($urandom_range(0, 1));
        data_in = 16'($urandom);
      end
      @(posedge clk); #1;
      edges++;
      if (done) begin
        seen = 1;
      end else begin
        if (quot !== last_q || remd !== last_r || dz !== last_dz) hold_bad = 1;
        if (busy !== 1'b1) busy_bad = 1;
      end
    end
    start = 1'b0;
    n_cmp++;
    if (!seen || edges != elat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d edges (seen=%0d) expected %0d", name, edges, seen, elat);
    end
    n_cmp++;
    if (quot !== eq) begin
      n_fail++;
      $display("FAIL %s quot: got %h expected %h", name, quot, eq);
    end
    n_cmp++;
    if (remd !== er) begin
      n_fail++;
      $display("FAIL %s remd: got %h expected %h", name, remd, er);
    end
    n_cmp++;
    if (dz !== edz) begin
      n_fail++;
      $display("FAIL %s dz: got %b expected %b", name, dz, edz);
    end
    n_cmp++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s busy_at_done: got %b expected 1", name, busy);
    end
    n_cmp++;
    if (hold_bad || busy_bad) begin
      n_fail++;
      $display("FAIL %s hold_during_op: got hold_bad=%0d busy_bad=%0d expected 0/0", name, hold_bad, busy_bad);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s after_done: got done=%b busy=%b expected 0/0", name, done, busy);
    end
    last_q = eq; last_r = er; last_dz = edz;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; data_in = 16'd0;
    #1;
    n_cmp++;
    if (quot !== 16'd0 || remd !== 16'd0 || dz !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got q=%h r=%h dz=%b done=%b busy=%b expected all 0", quot, remd, dz, done, busy);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    last_q = 16'd0; last_r = 16'd0; last_dz = 1'b0;
  endtask

  task automatic test_directed();
    do_op(16'd100,  16'd7, 1'b0, "100/7");
    do_op(16'd5,    16'd9, 1'b0, "5/9");
    do_op(16'd0,    16'd3, 1'b0, "0/3");
    do_op(16'd1234, 16'd0, 1'b0, "1234/0");
    do_op(16'd9,    16'd3, 1'b0, "9/3");
  endtask

  task automatic test_ignore_start();
    do_op(16'd50, 16'd5, 1'b1, "50/5_noise");
    do_op(16'd77, 16'd0, 1'b1, "77/0_noise");
  endtask

  task automatic test_back_to_back();
    int b;
    int a;
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 7) == 0) b = 0;
      else b = $urandom_range(1, 2000);
      a = $urandom_range(0, 65535);
      if (b != 0 && a / b > 60) a = b * $urandom_range(0, 60) + $urandom_range(0, b - 1);
      if (a > 65535) a = 65535;
      do_op(16'(a), 16'(b), 1'($urandom_range(0, 1)), "random");
    end
  endtask

  task automatic test_max();
    do_op(16'd65535, 16'd1, 1'b0, "65535/1");
  endtask

  task automatic test_reset_mid();
    bit saw_done;
    saw_done = 0;
    start = 1'b1; data_in = 16'd1000;
    @(posedge clk); #1;
    start = 1'b0; data_in = 16'd3;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done) saw_done = 1;
    end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (quot !== 16'd0 || remd !== 16'd0 || dz !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || saw_done) begin
      n_fail++;
      $display("FAIL reset_mid: got q=%h r=%h dz=%b done=%b busy=%b early_done=%0d expected all 0",
               quot, remd, dz, done, busy, saw_done);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    last_q = 16'd0; last_r = 16'd0; last_dz = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1;
    end
    n_cmp++;
    if (saw_done) begin
      n_fail++;
      $display("FAIL reset_mid_idle: got activity after reset expected none");
    end
    do_op(16'd10, 16'd4, 1'b0, "10/4_after_reset");
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset();
    test_directed();
    test_ignore_start();
    test_back_to_back();
    test_max();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
